// File: rtl/pkt_pkg.sv
// pkt_pkg: flit flow codes, default flit type and slice helper shared by pkt_dmem
package pkt_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, HEAD = 2'b01, BODY = 2'b10, TAIL = 2'b11} flow_t;
    localparam int FLIT_W_DEF = 16;
    typedef struct packed {flow_t flow; logic [FLIT_W_DEF-1:0] payload;} flit_t;
    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned fpw, input int unsigned flit_w);
        return (idx % fpw) * flit_w;
    endfunction
endpackage

// File: rtl/pkt_dmem_tx.sv
// pkt_dmem_tx: HEAD/BODY/TAIL flit streamer reading memory words under tx_ready backpressure
module pkt_dmem_tx
    import pkt_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FLIT_W = 16,
    parameter int DEPTH  = 256,
    parameter int PORT_W = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int FPW   = DATA_W / FLIT_W,
    localparam int PKT_W = FLIT_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send_i,
    input  logic [AW-1:0]     base_i,
    input  logic [AW:0]       len_i,
    input  logic [PORT_W-1:0] port_i,
    input  logic              tx_ready_i,
    input  logic [DATA_W-1:0] word_i,
    output logic [AW-1:0]     addr_o,
    output logic [PKT_W-1:0]  tx_o,
    output logic              busy_o,
    output logic              send_err_o
);
    localparam int CW = AW + 2 + $clog2(FPW);
    flow_t state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW:0] len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PKT_W-1:0] tx_q, tx_d;
    logic err_q;
    logic more;
    assign more = cnt_q < CW'(len_q) * CW'(FPW);
    assign addr_o = base_q + AW'(cnt_q / CW'(FPW));
    assign busy_o = state_q != IDLE;
    assign tx_o = tx_q;
    assign send_err_o = err_q;
    // state mirrors the flow code currently presented on tx
    always_comb begin
        state_d = state_q;
        base_d = base_q;
        len_d = len_q;
        cnt_d = cnt_q;
        tx_d = tx_q;
        if (state_q == IDLE) begin
            if (send_i) begin
                state_d = HEAD;
                base_d = base_i;
                len_d = len_i;
                cnt_d = '0;
                tx_d = {HEAD, FLIT_W'(port_i)};
            end
        end else if (tx_ready_i) begin
            if (state_q == TAIL) begin
                state_d = IDLE;
                tx_d = '0;
            end else if (more) begin
                state_d = BODY;
                cnt_d = cnt_q + 1'b1;
                tx_d = {BODY, word_i[slice_lsb(32'(cnt_q), FPW, FLIT_W) +: FLIT_W]};
            end else begin
                state_d = TAIL;
                tx_d = {TAIL, {FLIT_W{1'b0}}};
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
            tx_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q <= base_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
            tx_q <= tx_d;
            err_q <= send_i && state_q != IDLE;
        end
    end
endmodule

// File: rtl/pkt_dmem.sv
// pkt_dmem: PU data memory with flit DMA tx/rx; DMEM_RX_ADDR_HDR_EN makes the first rx BODY a word address
module pkt_dmem
    import pkt_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FLIT_W = 16,
    parameter int DEPTH  = 256,
    parameter int PORT_W = 4,
    parameter int PU_ID  = 0,
    localparam int AW    = $clog2(DEPTH),
    localparam int FPW   = DATA_W / FLIT_W,
    localparam int PKT_W = FLIT_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ad,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    output logic [DATA_W-1:0] rd,
    input  logic              send,
    input  logic [PORT_W-1:0] port,
    output logic              busy,
    output logic              send_err,
    output logic [PKT_W-1:0]  tx,
    input  logic              tx_ready,
    input  logic [PKT_W-1:0]  rx,
    output logic              rx_done
);
    localparam int PW = $clog2(DEPTH * FPW);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] tx_addr;
    logic [DATA_W-1:0] tx_word;
    logic [PW-1:0] ptr_q, ptr_d;
    logic in_pkt_q, in_pkt_d, done_q, wr_en;
    flow_t rx_flow;
    logic [FLIT_W-1:0] rx_pl;
    logic [AW-1:0] wr_word;
`ifdef DMEM_RX_ADDR_HDR_EN
    logic hdr_q, hdr_d;
`endif
    assign rx_flow = flow_t'(rx[PKT_W-1 -: 2]);
    assign rx_pl = rx[FLIT_W-1:0];
    assign rd = mem[ad];
    assign tx_word = mem[tx_addr];
    assign wr_word = AW'(ptr_q / PW'(FPW));
    assign rx_done = done_q;
    always_comb begin
        ptr_d = ptr_q;
        in_pkt_d = in_pkt_q;
        wr_en = 1'b0;
`ifdef DMEM_RX_ADDR_HDR_EN
        hdr_d = hdr_q;
`endif
        if (rx_flow == HEAD) begin
            ptr_d = '0;
            in_pkt_d = 1'b1;
`ifdef DMEM_RX_ADDR_HDR_EN
            hdr_d = 1'b1;
`endif
        end else if (rx_flow == TAIL) begin
            in_pkt_d = 1'b0;
        end else if (rx_flow == BODY && in_pkt_q) begin
`ifdef DMEM_RX_ADDR_HDR_EN
            if (hdr_q) begin
                hdr_d = 1'b0;
                ptr_d = PW'(rx_pl[AW-1:0]) * PW'(FPW);
            end else
`endif
            begin
                wr_en = 1'b1;
                ptr_d = (ptr_q == PW'(DEPTH * FPW - 1)) ? '0 : ptr_q + 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            in_pkt_q <= 1'b0;
            done_q <= 1'b0;
`ifdef DMEM_RX_ADDR_HDR_EN
            hdr_q <= 1'b0;
`endif
        end else begin
            ptr_q <= ptr_d;
            in_pkt_q <= in_pkt_d;
            done_q <= rx_flow == TAIL && in_pkt_q;
`ifdef DMEM_RX_ADDR_HDR_EN
            hdr_q <= hdr_d;
`endif
        end
    end
    // memory is never reset; the rx slice write comes last so it wins a same-word collision
    always_ff @(posedge clk) begin
        if (we) mem[ad] <= wd;
        if (wr_en) mem[wr_word][slice_lsb(32'(ptr_q), FPW, FLIT_W) +: FLIT_W] <= rx_pl;
    end
    pkt_dmem_tx #(
        .DATA_W(DATA_W),
        .FLIT_W(FLIT_W),
        .DEPTH (DEPTH),
        .PORT_W(PORT_W)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .send_i    (send),
        .base_i    (ad),
        .len_i     (wd[AW:0]),
        .port_i    (port),
        .tx_ready_i(tx_ready),
        .word_i    (tx_word),
        .addr_o    (tx_addr),
        .tx_o      (tx),
        .busy_o    (busy),
        .send_err_o(send_err)
    );
endmodule

// File: tb/tb_pkt_dmem.sv
// tb_pkt_dmem: packet-level model of pkt_dmem checked every cycle, plus directed literal expectations
module tb_pkt_dmem;
    logic clk = 0, rst;
    logic [7:0] ad = 0;
    logic [31:0] wd = 0, rd;
    logic we = 0, send = 0, busy, send_err, tx_ready = 1, rx_done;
    logic [3:0] port = 0;
    logic [17:0] tx, rx = 0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    pkt_dmem dut (
        .clk(clk), .rst(rst), .ad(ad), .wd(wd), .we(we), .rd(rd), .send(send), .port(port),
        .busy(busy), .send_err(send_err), .tx(tx), .tx_ready(tx_ready), .rx(rx), .rx_done(rx_done)
    );
    logic [31:0] mm [256];
    logic [17:0] q[$], seen[$];
    logic [15:0] rq[$];
    bit in_pkt, e_err, e_done, b;
    initial for (int i = 0; i < 256; i++) mm[i] = 0;
    function automatic void fill(input logic [7:0] base, input int len, input logic [3:0] p);
        logic [31:0] w;
        q.push_back({2'b01, 12'h0, p});
        for (int f = 0; f < len * 2; f++) begin
            w = mm[8'(base + f / 2)];
            q.push_back({2'b10, (f % 2) ? w[31:16] : w[15:0]});
        end
        q.push_back(18'h30000);
    endfunction
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            in_pkt = 0;
            e_err = 0;
            e_done = 0;
        end else begin
            b = q.size() != 0;
            e_err = send && b;
            if (b && tx_ready) void'(q.pop_front());
            if (!b && send) fill(ad, int'(wd[8:0]), port);
            if (we) mm[ad] = wd;
            e_done = 0;
            if (rx[17:16] == 2'b01) begin
                rq.delete();
                in_pkt = 1;
            end else if (rx[17:16] == 2'b10 && in_pkt) rq.push_back(rx[15:0]);
            else if (rx[17:16] == 2'b11 && in_pkt) begin
                for (int i = 0; i < rq.size(); i++)
                    if (i % 2) mm[8'(i / 2)][31:16] = rq[i];
                    else mm[8'(i / 2)][15:0] = rq[i];
                in_pkt = 0;
                e_done = 1;
            end
        end
    end
    always @(posedge clk) if (!rst && tx != 0 && tx_ready) seen.push_back(tx);
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic chk_seq(input string nm, input logic [17:0] e[$]);
        int bad = -1;
        checks++;
        for (int i = 0; i < e.size() && bad < 0; i++)
            if (i >= seen.size() || seen[i] !== e[i]) bad = i;
        if (bad < 0 && seen.size() != e.size()) bad = e.size();
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s flits=%0d expected_flits=%0d first_diff=%0d actual=%0h expected=%0h", nm, seen.size(),
                     e.size(), bad, bad < seen.size() ? seen[bad] : 18'h0, bad < e.size() ? e[bad] : 18'h0);
        end
    endtask
    always @(negedge clk) if (!rst) begin
        chk("model_tx", tx, q.size() != 0 ? q[0] : 18'h0);
        chk("model_busy", busy, q.size() != 0);
        chk("model_send_err", send_err, e_err);
        chk("model_rx_done", rx_done, e_done);
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        ad = a; wd = d; we = 1;
        tick;
        we = 0;
    endtask
    task automatic snd(input logic [7:0] a, input logic [31:0] l, input logic [3:0] p);
        ad = a; wd = l; port = p; send = 1;
        tick;
        send = 0;
    endtask
    task automatic rxf(input logic [1:0] fl, input logic [15:0] pl);
        rx = {fl, pl};
        tick;
        rx = 0;
    endtask
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            tick;
            n++;
        end
        chk("idle_in_time", n < 100, 1);
    endtask
    initial begin
        logic [17:0] e[$];
        int n;
        rst = 1;
        tick;
        tick;
        chk("rst_tx", tx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_send_err", send_err, 0);
        chk("rst_rx_done", rx_done, 0);
        rst = 0;
        tick;
        wr(3, 32'hAABBCCDD);
        wr(4, 32'h11223344);
        seen.delete();
        snd(3, 2, 5);
        wait_idle(n);
        chk("t1_busy_cycles", n, 6);
        e = '{18'h10005, 18'h2CCDD, 18'h2AABB, 18'h23344, 18'h21122, 18'h30000};
        chk_seq("t1_seq", e);
        seen.delete();
        snd(3, 2, 5);
        n = 0;
        while (tx !== 18'h2AABB && n < 20) begin
            tick;
            n++;
        end
        chk("t2_reach_aabb", n < 20, 1);
        tx_ready = 0;
        repeat (3) begin
            tick;
            chk("t2_hold", tx, 18'h2AABB);
        end
        tx_ready = 1;
        wait_idle(n);
        chk_seq("t2_seq", e);
        rxf(2'b01, 0);
        rxf(2'b10, 16'h5678);
        rxf(2'b10, 16'h1234);
        rxf(2'b11, 0);
        chk("t3_rx_done", rx_done, 1);
        tick;
        chk("t3_rx_done_clr", rx_done, 0);
        ad = 0;
        #1 chk("t3_mem0", rd, 32'h12345678);
        seen.delete();
        snd(3, 2, 5);
        snd(10, 1, 1);
        chk("t4_send_err", send_err, 1);
        tick;
        chk("t4_send_err_clr", send_err, 0);
        wait_idle(n);
        chk_seq("t4_seq", e);
        seen.delete();
        snd(20, 0, 7);
        wait_idle(n);
        chk("t4_len0_cycles", n, 2);
        e = '{18'h10007, 18'h30000};
        chk_seq("t4_len0_seq", e);
        wr(255, 32'hDEADBEEF);
        seen.delete();
        snd(255, 2, 2);
        wait_idle(n);
        e = '{18'h10002, 18'h2BEEF, 18'h2DEAD, 18'h25678, 18'h21234, 18'h30000};
        chk_seq("t5_wrap_seq", e);
        rxf(2'b10, 16'hFFFF);
        rxf(2'b11, 0);
        chk("t5_stray_no_done", rx_done, 0);
        ad = 0;
        #1 chk("t5_stray_mem0", rd, 32'h12345678);
        rxf(2'b01, 0);
        we = 1; ad = 0; wd = 32'h11112222; rx = {2'b10, 16'hAAAA};
        tick;
        we = 0; rx = 0;
        rxf(2'b11, 0);
        ad = 0;
        #1 chk("collision_mem0", rd, 32'h1111AAAA);
        seen.delete();
        snd(3, 2, 5);
        n = 0;
        while (tx[17:16] !== 2'b10 && n < 20) begin
            tick;
            n++;
        end
        chk("t6_reach_body", n < 20, 1);
        tick;
        rst = 1;
        #1;
        chk("t6_rst_tx", tx, 0);
        chk("t6_rst_busy", busy, 0);
        tick;
        rst = 0;
        tick;
        ad = 3;
        #1 chk("t6_mem3", rd, 32'hAABBCCDD);
        seen.delete();
        snd(3, 1, 9);
        wait_idle(n);
        e = '{18'h10009, 18'h2CCDD, 18'h2AABB, 18'h30000};
        chk_seq("t6_resend_seq", e);
        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
